// File: rtl/mem_bus2_pkg.sv
// Shared types for the cache<->memory bus 2: command encoding, controller states and
// beat-geometry helpers.
package mem_bus2_pkg;

  typedef enum logic [1:0] {
    C2Nop       = 2'd0,
    C2Response  = 2'd1,
    C2ReadLine  = 2'd2,
    C2WriteLine = 2'd3
  } c2_cmd_t;

  typedef enum logic [2:0] {
    StIdle,
    StWrRecv,
    StWrWait,
    StRdWait,
    StRdSend
  } state_t;

  function automatic int unsigned beat_bytes(int unsigned data_w);
    return data_w / 8;
  endfunction

  function automatic int unsigned beats(int unsigned line_bytes, int unsigned data_w);
    return line_bytes / beat_bytes(data_w);
  endfunction

endpackage

// File: rtl/mem_ctr_line_if.sv
// Bus 2 signal bundle between the cache (master) and the memory controller (slave), with
// the tri-state wires split into in/out/oe.
interface mem_ctr_line_if
  import mem_bus2_pkg::*;
#(
  parameter int unsigned ADDR_W = 14,
  parameter int unsigned DATA_W = 16
);

  logic [ADDR_W-1:0] a2_in;
  logic [DATA_W-1:0] d2_in;
  logic [DATA_W-1:0] d2_out;
  logic              d2_oe;
  c2_cmd_t           c2_in;
  c2_cmd_t           c2_out;
  logic              c2_oe;
  logic              busy;

  modport master (
    output a2_in, d2_in, c2_in,
    input  d2_out, d2_oe, c2_out, c2_oe, busy
  );

  modport slave (
    input  a2_in, d2_in, c2_in,
    output d2_out, d2_oe, c2_out, c2_oe, busy
  );

endinterface

// File: rtl/mem_line_array.sv
// Line store: byte-enabled beat-wide write port and combinational beat-wide read port,
// word index = line * BEATS + beat.
module mem_line_array #(
  parameter int unsigned LINE_W     = 14,
  parameter int unsigned BEATS      = 8,
  parameter int unsigned BEAT_BYTES = 2,
  parameter int unsigned BEAT_W     = (BEATS > 1) ? $clog2(BEATS) : 1
) (
  input  logic                      clk_i,
  input  logic                      we_i,
  input  logic [BEAT_BYTES-1:0]     be_i,
  input  logic [LINE_W-1:0]         wline_i,
  input  logic [BEAT_W-1:0]         wbeat_i,
  input  logic [8*BEAT_BYTES-1:0]   wdata_i,
  input  logic [LINE_W-1:0]         rline_i,
  input  logic [BEAT_W-1:0]         rbeat_i,
  output logic [8*BEAT_BYTES-1:0]   rdata_o
);

  localparam int unsigned NumWords = (1 << LINE_W) * BEATS;
  localparam int unsigned IdxW     = $clog2(NumWords);

  function automatic logic [IdxW-1:0] word_idx(logic [LINE_W-1:0] line, logic [BEAT_W-1:0] beat);
    return IdxW'(line) * IdxW'(BEATS) + IdxW'(beat);
  endfunction

  logic [8*BEAT_BYTES-1:0] mem_q [NumWords];
  logic [IdxW-1:0]         widx;
  logic [IdxW-1:0]         ridx;

  assign widx    = word_idx(wline_i, wbeat_i);
  assign ridx    = word_idx(rline_i, rbeat_i);
  assign rdata_o = mem_q[ridx];

  // No reset: contents survive RESET by design.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int unsigned j = 0; j < BEAT_BYTES; j++) begin
        if (be_i[j]) begin
          mem_q[widx][8*j +: 8] <= wdata_i[8*j +: 8];
        end
      end
    end
  end

endmodule

// File: rtl/mem_ctr_line.sv
// Bus 2 memory controller: line reads/writes with fixed access latency, all outputs
// registered on posedge, explicit drive enables for the shared C2/D2 wires.
module mem_ctr_line
  import mem_bus2_pkg::*;
#(
  parameter int unsigned ADDR_W     = 14,
  parameter int unsigned LINE_BYTES = 16,
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned MEM_DELAY  = 100
) (
  input logic           CLK,
  input logic           RESET,
  mem_ctr_line_if.slave bus2
);

  localparam int unsigned BeatBytes = beat_bytes(DATA_W);
  localparam int unsigned Beats     = beats(LINE_BYTES, DATA_W);
  localparam int unsigned BeatW     = (Beats > 1) ? $clog2(Beats) : 1;
  localparam int unsigned CntW      = $clog2(MEM_DELAY + 1);
  localparam logic [CntW-1:0]  RespCnt  = CntW'(MEM_DELAY - 1);
  localparam logic [CntW-1:0]  DoneCnt  = CntW'(MEM_DELAY);
  localparam logic [BeatW-1:0] LastBeat = BeatW'(Beats - 1);

  if (MEM_DELAY < Beats + 1) begin : g_bad_delay
    $error("mem_ctr_line: MEM_DELAY must be at least BEATS+1");
  end
  if ((DATA_W % 8 != 0) || ((LINE_BYTES * 8) % DATA_W != 0)) begin : g_bad_width
    $error("mem_ctr_line: DATA_W must be a byte multiple dividing the line width");
  end

  state_t            state_q;
  logic [ADDR_W-1:0] line_q;
  logic [BeatW-1:0]  beat_q;
  logic [BeatW-1:0]  beat_inc;
  logic [CntW-1:0]   cnt_q;
  c2_cmd_t           c2_out_q;
  logic              c2_oe_q;
  logic [DATA_W-1:0] d2_out_q;
  logic              d2_oe_q;
  logic              busy_q;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_wline;
  logic [DATA_W-1:0] mem_rdata;

  assign beat_inc = (beat_q == LastBeat) ? '0 : beat_q + BeatW'(1);

  // Beat 0 of a write lands on the command edge, before line_q holds the address.
  always_comb begin
    mem_we    = 1'b0;
    mem_wline = line_q;
    if (!RESET) begin
      unique case (state_q)
        StIdle: begin
          if (bus2.c2_in == C2WriteLine) begin
            mem_we    = 1'b1;
            mem_wline = bus2.a2_in;
          end
        end
        StWrRecv: mem_we = 1'b1;
        default: ;
      endcase
    end
  end

  mem_line_array #(
    .LINE_W    (ADDR_W),
    .BEATS     (Beats),
    .BEAT_BYTES(BeatBytes),
    .BEAT_W    (BeatW)
  ) u_array (
    .clk_i  (CLK),
    .we_i   (mem_we),
    .be_i   ({BeatBytes{1'b1}}),
    .wline_i(mem_wline),
    .wbeat_i(beat_q),
    .wdata_i(bus2.d2_in),
    .rline_i(line_q),
    .rbeat_i(beat_q),
    .rdata_o(mem_rdata)
  );

  // cnt_q equals the edge number (relative to the command edge) at the edge being evaluated.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q  <= StIdle;
      line_q   <= '0;
      beat_q   <= '0;
      cnt_q    <= '0;
      c2_out_q <= C2Nop;
      c2_oe_q  <= 1'b0;
      d2_out_q <= '0;
      d2_oe_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          cnt_q <= CntW'(1);
          if (bus2.c2_in == C2WriteLine) begin
            line_q  <= bus2.a2_in;
            beat_q  <= beat_inc;
            state_q <= (beat_inc == '0) ? StWrWait : StWrRecv;
            busy_q  <= 1'b1;
          end else if (bus2.c2_in == C2ReadLine) begin
            line_q  <= bus2.a2_in;
            beat_q  <= '0;
            state_q <= StRdWait;
            busy_q  <= 1'b1;
          end
        end
        StWrRecv: begin
          cnt_q  <= cnt_q + CntW'(1);
          beat_q <= beat_inc;
          if (beat_inc == '0) state_q <= StWrWait;
        end
        StWrWait: begin
          cnt_q <= cnt_q + CntW'(1);
          if (cnt_q == DoneCnt) begin
            state_q  <= StIdle;
            c2_oe_q  <= 1'b0;
            c2_out_q <= C2Nop;
            busy_q   <= 1'b0;
          end else begin
            c2_oe_q  <= 1'b1;
            c2_out_q <= (cnt_q == RespCnt) ? C2Response : C2Nop;
          end
        end
        StRdWait: begin
          cnt_q   <= cnt_q + CntW'(1);
          c2_oe_q <= 1'b1;
          if (cnt_q == RespCnt) begin
            c2_out_q <= C2Response;
            d2_oe_q  <= 1'b1;
            d2_out_q <= mem_rdata;
            beat_q   <= beat_inc;
            state_q  <= StRdSend;
          end else begin
            c2_out_q <= C2Nop;
          end
        end
        StRdSend: begin
          if (beat_q == '0) begin
            state_q  <= StIdle;
            c2_oe_q  <= 1'b0;
            c2_out_q <= C2Nop;
            d2_oe_q  <= 1'b0;
            busy_q   <= 1'b0;
          end else begin
            d2_out_q <= mem_rdata;
            beat_q   <= beat_inc;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus2.c2_out = c2_out_q;
  assign bus2.c2_oe  = c2_oe_q;
  assign bus2.d2_out = d2_out_q;
  assign bus2.d2_oe  = d2_oe_q;
  assign bus2.busy   = busy_q;

endmodule
